// File: rtl/softreg_pkg.sv
// -----------------------------------------------------------------------------
// softreg_pkg
// Shared definitions for the SoftReg host-side command sequencer:
//   - sequencer FSM state encoding
//   - softreg_cmd_t, one command-table entry {is_write, poll, addr, data}
//   - SoftReg address map constants used by the PageRank register block
// Table entries are stored at the maximum supported widths (SR_ADDR_MAX /
// SR_DATA_MAX); the sequencer's ADDR_W / DATA_W must not exceed them.
// -----------------------------------------------------------------------------
package softreg_pkg;

  localparam int SR_ADDR_MAX = 32;
  localparam int SR_DATA_MAX = 64;

  // SoftReg address map.
  localparam logic [31:0] WRITE_ADDR0 = 32'h0000_0010;
  localparam logic [31:0] DONE_ALL    = 32'h0000_0030;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic                   is_write;
    logic                   poll;
    logic [SR_ADDR_MAX-1:0] addr;
    logic [SR_DATA_MAX-1:0] data;
  } softreg_cmd_t;

endpackage

// File: rtl/softreg_cmd_table.sv
// -----------------------------------------------------------------------------
// softreg_cmd_table
// Command storage for softreg_cmd_seq: synchronous write, asynchronous read.
// Contents are not reset.
// Ports:
//   clk        in   clock
//   wr_en_i    in   write strobe (caller guarantees wr_idx_i < N_CMDS)
//   wr_idx_i   in   write index
//   wr_cmd_i   in   entry to store
//   rd_idx_i   in   read index
//   rd_cmd_o   out  entry at rd_idx_i (combinational)
// -----------------------------------------------------------------------------
module softreg_cmd_table
  import softreg_pkg::*;
#(
  parameter int N_CMDS = 8,
  parameter int IDX_W  = $clog2(N_CMDS)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  softreg_cmd_t     wr_cmd_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output softreg_cmd_t     rd_cmd_o
);

  softreg_cmd_t mem_q [0:N_CMDS-1];

  // Table write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_cmd_i;
    end
  end

  assign rd_cmd_o = mem_q[rd_idx_i];

endmodule

// File: rtl/softreg_cmd_seq.sv
// -----------------------------------------------------------------------------
// softreg_cmd_seq
// Host-side SoftReg command sequencer. A table of N_CMDS write/read commands
// is loaded while idle; on start the first cmd_count entries are issued in
// order, each read waiting (bounded by TIMEOUT_CYC) for its response. GAP_CYC
// idle cycles follow every completed command. All outputs are registered.
//
// Optional feature (macro SOFTREG_CMD_SEQ_POLL_EN): adds port cmd_wr_poll and
// a per-entry poll bit. A poll read answered with zero is reissued after the
// gap until a nonzero response arrives or the total timeout expires.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   cmd_wr_en/idx/is_write/
//   cmd_wr_addr/cmd_wr_data     table load port (IDLE only)
//   cmd_wr_poll                 poll bit (only with SOFTREG_CMD_SEQ_POLL_EN)
//   cmd_count, start            run length and run trigger
//   softreg_req_*               request channel (valid is a 1-cycle strobe)
//   softreg_resp_valid/data     read response channel
//   res_valid/idx/data          completed-read report
//   busy, done, timeout_err     status (timeout_err sticky until next run)
// -----------------------------------------------------------------------------
module softreg_cmd_seq
  import softreg_pkg::*;
#(
  parameter int N_CMDS      = 8,
  parameter int IDX_W       = $clog2(N_CMDS),
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_wr_en,
  input  logic [IDX_W-1:0]  cmd_wr_idx,
  input  logic              cmd_wr_is_write,
  input  logic [ADDR_W-1:0] cmd_wr_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
`ifdef SOFTREG_CMD_SEQ_POLL_EN
  input  logic              cmd_wr_poll,
`endif
  input  logic [IDX_W:0]    cmd_count,
  input  logic              start,
  output logic              softreg_req_valid,
  output logic              softreg_req_isWrite,
  output logic [ADDR_W-1:0] softreg_req_addr,
  output logic [DATA_W-1:0] softreg_req_data,
  input  logic              softreg_resp_valid,
  input  logic [DATA_W-1:0] softreg_resp_data,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int CW = IDX_W + 1;
  localparam int GW = $clog2(GAP_CYC + 2);
  // Headroom so the poll-mode count cannot wrap while crossing a gap.
  localparam int TW = $clog2(TIMEOUT_CYC + GAP_CYC + 4) + 1;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              in_poll_q, in_poll_d;
  logic              cur_poll_q, cur_poll_d;
  logic              req_valid_q, req_valid_d;
  logic              req_iswrite_q, req_iswrite_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              res_valid_q, res_valid_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;

  logic              load_req_s;
  logic              cmd_end_s;
  logic              next_cmd_s;
  logic              count_ok_s;
  logic              last_s;
  logic              tbl_we_s;
  softreg_cmd_t      wr_cmd_s;
  softreg_cmd_t      rd_cmd_s;

  assign count_ok_s = (cmd_count != CW'(0)) && (int'(cmd_count) <= N_CMDS);
  assign last_s     = (CW'(idx_q) == (count_q - CW'(1)));
  assign tbl_we_s   = (state_q == IDLE) && cmd_wr_en && (int'(cmd_wr_idx) < N_CMDS);

  // Pack the load port into a table entry.
  always_comb begin
    wr_cmd_s          = '0;
    wr_cmd_s.is_write = cmd_wr_is_write;
`ifdef SOFTREG_CMD_SEQ_POLL_EN
    wr_cmd_s.poll     = cmd_wr_poll;
`else
    wr_cmd_s.poll     = 1'b0;
`endif
    wr_cmd_s.addr     = SR_ADDR_MAX'(cmd_wr_addr);
    wr_cmd_s.data     = SR_DATA_MAX'(cmd_wr_data);
  end

  // The read port looks at the index the FSM moves to, so the request
  // registers can be loaded on the same edge as the entry into ISSUE.
  softreg_cmd_table #(
    .N_CMDS (N_CMDS),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk      (clk),
    .wr_en_i  (tbl_we_s),
    .wr_idx_i (cmd_wr_idx),
    .wr_cmd_i (wr_cmd_s),
    .rd_idx_i (idx_d),
    .rd_cmd_o (rd_cmd_s)
  );

  // Sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    in_poll_d   = in_poll_q;
    terr_d      = terr_q;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    load_req_s  = 1'b0;
    cmd_end_s   = 1'b0;
    next_cmd_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_ok_s) begin
            state_d    = ISSUE;
            idx_d      = IDX_W'(0);
            count_d    = cmd_count;
            terr_d     = 1'b0;
            in_poll_d  = 1'b0;
            load_req_s = 1'b1;
          end else begin
            // Empty or oversized run: report completion without issuing.
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (req_iswrite_q) begin
          cmd_end_s = 1'b1;
        end else begin
          state_d = WAIT;
          // A poll reissue keeps counting from the first issue.
          tmo_d   = in_poll_q ? (tmo_q + TW'(1)) : TW'(0);
        end
      end
      WAIT: begin
        if (softreg_resp_valid) begin
          if (cur_poll_q && (softreg_resp_data == DATA_W'(0))) begin
            in_poll_d = 1'b1;
            tmo_d     = tmo_q + TW'(1);
            if (GAP_CYC > 0) begin
              state_d = GAP;
              gap_d   = GW'(0);
            end else begin
              state_d    = ISSUE;
              load_req_s = 1'b1;
            end
          end else begin
            res_valid_d = 1'b1;
            res_idx_d   = idx_q;
            res_data_d  = softreg_resp_data;
            in_poll_d   = 1'b0;
            cmd_end_s   = 1'b1;
          end
        end else if (int'(tmo_q) >= (TIMEOUT_CYC - 1)) begin
          // Response checked first: one arriving on the last cycle still wins.
          terr_d    = 1'b1;
          in_poll_d = 1'b0;
          state_d   = DONE;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (in_poll_q) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          tmo_d = tmo_q;
        end
        if (int'(gap_q) >= (GAP_CYC - 1)) begin
          if (in_poll_q) begin
            state_d    = ISSUE;
            load_req_s = 1'b1;
          end else begin
            next_cmd_s = 1'b1;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completed command: insert the gap, or go straight to the next one.
    if (cmd_end_s) begin
      if (GAP_CYC > 0) begin
        state_d = GAP;
        gap_d   = GW'(0);
      end else begin
        next_cmd_s = 1'b1;
      end
    end else begin
      next_cmd_s = next_cmd_s;
    end

    if (next_cmd_s) begin
      if (last_s) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        idx_d      = idx_q + IDX_W'(1);
        state_d    = ISSUE;
        load_req_s = 1'b1;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Request register loading from the table entry being issued.
  always_comb begin
    req_valid_d   = 1'b0;
    req_iswrite_d = req_iswrite_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    cur_poll_d    = cur_poll_q;
    if (load_req_s) begin
      req_valid_d   = 1'b1;
      req_iswrite_d = rd_cmd_s.is_write;
      req_addr_d    = ADDR_W'(rd_cmd_s.addr);
      req_data_d    = DATA_W'(rd_cmd_s.data);
      cur_poll_d    = rd_cmd_s.poll & ~rd_cmd_s.is_write;
    end else begin
      req_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= IDX_W'(0);
      count_q       <= CW'(0);
      gap_q         <= GW'(0);
      tmo_q         <= TW'(0);
      in_poll_q     <= 1'b0;
      cur_poll_q    <= 1'b0;
      req_valid_q   <= 1'b0;
      req_iswrite_q <= 1'b0;
      req_addr_q    <= ADDR_W'(0);
      req_data_q    <= DATA_W'(0);
      res_valid_q   <= 1'b0;
      res_idx_q     <= IDX_W'(0);
      res_data_q    <= DATA_W'(0);
      done_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      in_poll_q     <= in_poll_d;
      cur_poll_q    <= cur_poll_d;
      req_valid_q   <= req_valid_d;
      req_iswrite_q <= req_iswrite_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      res_valid_q   <= res_valid_d;
      res_idx_q     <= res_idx_d;
      res_data_q    <= res_data_d;
      done_q        <= done_d;
      terr_q        <= terr_d;
    end
  end

  assign softreg_req_valid   = req_valid_q;
  assign softreg_req_isWrite = req_iswrite_q;
  assign softreg_req_addr    = req_addr_q;
  assign softreg_req_data    = req_data_q;
  assign res_valid           = res_valid_q;
  assign res_idx             = res_idx_q;
  assign res_data            = res_data_q;
  assign busy                = (state_q != IDLE);
  assign done                = done_q;
  assign timeout_err         = terr_q;

endmodule

// File: tb/tb_softreg_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_softreg_cmd_seq
// Self-checking bench for softreg_cmd_seq (N_CMDS=8, GAP_CYC=2,
// TIMEOUT_CYC=16). A monitor logs requests, results and done pulses with cycle
// stamps; a responder answers reads from a per-read plan. Expected timelines
// are computed from the command list with plain cycle arithmetic.
// -----------------------------------------------------------------------------
module tb_softreg_cmd_seq;
  import softreg_pkg::*;

  localparam int N   = 8;
  localparam int GAP = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_wr_en = 1'b0;
  logic [2:0]  cmd_wr_idx = 3'd0;
  logic        cmd_wr_is_write = 1'b0;
  logic [31:0] cmd_wr_addr = 32'd0;
  logic [63:0] cmd_wr_data = 64'd0;
  logic        cmd_wr_poll = 1'b0;
  logic [3:0]  cmd_count = 4'd0;
  logic        start = 1'b0;
  logic        req_valid, req_iswrite;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        res_valid;
  logic [2:0]  res_idx;
  logic [63:0] res_data;
  logic        busy, done, timeout_err;

  softreg_cmd_seq #(
    .N_CMDS(N), .ADDR_W(32), .DATA_W(64), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_idx(cmd_wr_idx),
    .cmd_wr_is_write(cmd_wr_is_write), .cmd_wr_addr(cmd_wr_addr),
    .cmd_wr_data(cmd_wr_data),
`ifdef SOFTREG_CMD_SEQ_POLL_EN
    .cmd_wr_poll(cmd_wr_poll),
`endif
    .cmd_count(cmd_count), .start(start),
    .softreg_req_valid(req_valid), .softreg_req_isWrite(req_iswrite),
    .softreg_req_addr(req_addr), .softreg_req_data(req_data),
    .softreg_resp_valid(resp_valid), .softreg_resp_data(resp_data),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic w; logic [31:0] a; logic [63:0] d; } req_ev_t;
  typedef struct { int t; logic [2:0] idx; logic [63:0] d; } res_ev_t;
  typedef struct { int t; logic err; } done_ev_t;

  req_ev_t  req_log[$];
  res_ev_t  res_log[$];
  done_ev_t done_log[$];

  // Per-read response plan, consumed in issue order by the monitor.
  int          plan_dly [1024];
  bit          plan_nr  [1024];
  logic [63:0] plan_dat [1024];
  int          plan_rd = 0;
  int          resp_t = -1;
  logic [63:0] resp_dv = 64'd0;

  // Reference table contents and sticky error.
  bit          m_w [N];
  logic [31:0] m_a [N];
  logic [63:0] m_d [N];
  bit          m_err = 1'b0;

  int tests = 0;
  int fails = 0;
  int last_c0 = 0;

  // Monitor: sample outputs mid-cycle and schedule read responses.
  always @(negedge clk) begin
    if (req_valid) begin
      req_log.push_back('{cyc, req_iswrite, req_addr, req_data});
      if (!req_iswrite) begin
        if (!plan_nr[plan_rd]) begin
          resp_t  = cyc + 1 + plan_dly[plan_rd];
          resp_dv = plan_dat[plan_rd];
        end
        plan_rd = plan_rd + 1;
      end
    end
    if (res_valid) res_log.push_back('{cyc, res_idx, res_data});
    if (done) done_log.push_back('{cyc, timeout_err});
  end

  // Responder: drives resp_valid for exactly the scheduled cycle.
  initial begin
    resp_valid = 1'b0;
    resp_data  = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc == resp_t) begin
        resp_valid = 1'b1;
        resp_data  = resp_dv;
      end else begin
        resp_valid = 1'b0;
        resp_data  = 64'd0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int i, input bit w, input logic [31:0] a,
                      input logic [63:0] d, input bit p);
    cmd_wr_en = 1'b1; cmd_wr_idx = 3'(i); cmd_wr_is_write = w;
    cmd_wr_addr = a; cmd_wr_data = d; cmd_wr_poll = p;
    tick(1);
    cmd_wr_en = 1'b0;
    m_w[i] = w; m_a[i] = a; m_d[i] = d;
  endtask

  task automatic plan(input int k, input int dly, input bit nr, input logic [63:0] dat);
    plan_dly[plan_rd + k] = dly;
    plan_nr[plan_rd + k]  = nr;
    plan_dat[plan_rd + k] = dat;
  endtask

  // Run cmd_count=count and compare every logged event with the timeline
  // derived from the table and response plan.
  task automatic run(input int count, input bit inject);
    int rb, sb, db, c0, n, t, pk, e_done;
    bit valid, ab;
    req_ev_t exp_req[$];
    res_ev_t exp_res[$];
    rb = req_log.size(); sb = res_log.size(); db = done_log.size(); pk = plan_rd;
    valid = (count >= 1) && (count <= N);
    cmd_count = 4'(count); start = 1'b1; c0 = cyc; last_c0 = c0;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, {63'd0, valid});
    if (valid) chk("err_cleared_on_start", {63'd0, timeout_err}, 64'd0);
    n = 0;
    while (done_log.size() == db && n < 400) begin
      if (inject && n == 4) begin
        start = 1'b1; cmd_count = 4'd1;
        cmd_wr_en = 1'b1; cmd_wr_idx = 3'd0; cmd_wr_is_write = 1'b1;
        cmd_wr_addr = 32'hDEAD_0000; cmd_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        start = 1'b0; cmd_wr_en = 1'b0;
      end
      tick(1);
      n++;
    end
    start = 1'b0; cmd_wr_en = 1'b0;
    tick(3);

    t = c0 + 1; ab = 1'b0; e_done = c0 + 1;
    if (valid) begin
      m_err = 1'b0;
      for (int i = 0; i < count && !ab; i++) begin
        exp_req.push_back('{t, m_w[i], m_a[i], m_d[i]});
        if (m_w[i]) begin
          t = t + 1 + GAP;
        end else if (plan_nr[pk]) begin
          e_done = t + 1 + TMO; m_err = 1'b1; ab = 1'b1; pk++;
        end else begin
          exp_res.push_back('{t + 2 + plan_dly[pk], 3'(i), plan_dat[pk]});
          t = t + 2 + plan_dly[pk] + GAP; pk++;
        end
      end
      if (!ab) e_done = t;
    end

    chk("done_pulses", 64'(done_log.size() - db), 64'd1);
    if (done_log.size() > db) begin
      chk("done_cycle", 64'(done_log[db].t), 64'(e_done));
      chk("err_at_done", {63'd0, done_log[db].err}, {63'd0, m_err});
    end
    chk("req_count", 64'(req_log.size() - rb), 64'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && (rb + i) < req_log.size(); i++) begin
      chk("req_cycle", 64'(req_log[rb + i].t), 64'(exp_req[i].t));
      chk("req_kind", {63'd0, req_log[rb + i].w}, {63'd0, exp_req[i].w});
      chk("req_addr", {32'd0, req_log[rb + i].a}, {32'd0, exp_req[i].a});
      if (exp_req[i].w) chk("req_data", req_log[rb + i].d, exp_req[i].d);
    end
    chk("res_count", 64'(res_log.size() - sb), 64'(exp_res.size()));
    for (int i = 0; i < exp_res.size() && (sb + i) < res_log.size(); i++) begin
      chk("res_cycle", 64'(res_log[sb + i].t), 64'(exp_res[i].t));
      chk("res_idx", {61'd0, res_log[sb + i].idx}, {61'd0, exp_res[i].idx});
      chk("res_data", res_log[sb + i].d, exp_res[i].d);
    end
    chk("idle_after_run", {63'd0, busy}, 64'd0);
    chk("err_sticky", {63'd0, timeout_err}, {63'd0, m_err});
  endtask

  initial begin
    int db, cnt;
    // Reset state.
    tick(3);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    chk("rst_req_addr", {32'd0, req_addr}, 64'd0);
    rst = 1'b1;
    tick(2);

    // Write then read of DONE_ALL, response 3 cycles after the read request.
    load(0, 1'b1, WRITE_ADDR0, 64'd256, 1'b0);
    load(1, 1'b0, DONE_ALL, 64'd0, 1'b0);
    plan(0, 2, 1'b0, 64'h0000_0000_0000_00A5);
    run(2, 1'b0);

    // Four writes: requests 3 cycles apart, done 13 cycles after start.
    for (int i = 0; i < 4; i++) load(i, 1'b1, 32'h100 + 32'(i), 64'(i * 7 + 1), 1'b0);
    run(4, 1'b0);
    chk("four_write_done_latency", 64'(done_log[done_log.size() - 1].t - last_c0), 64'd13);

    // Read with no response: timeout after 16 WAIT cycles; next start clears it.
    load(0, 1'b0, DONE_ALL, 64'd0, 1'b0);
    plan(0, 0, 1'b1, 64'd0);
    run(1, 1'b0);
    // Response on the last permitted cycle is accepted.
    plan(0, TMO - 1, 1'b0, 64'h1234_5678_9ABC_DEF0);
    run(1, 1'b0);

    // Invalid run lengths: done next cycle, no requests; error left untouched.
    plan(0, 0, 1'b1, 64'd0);
    run(1, 1'b0);
    run(0, 1'b0);
    run(9, 1'b0);

    // start and table writes during a run are ignored.
    for (int i = 0; i < 4; i++) load(i, 1'b1, 32'h200 + 32'(i), 64'(i + 100), 1'b0);
    run(4, 1'b1);

    // Reset mid-WAIT: outputs clear at once, no done, fresh run afterwards.
    load(0, 1'b0, DONE_ALL, 64'd0, 1'b0);
    plan(0, 0, 1'b1, 64'd0);
    cmd_count = 4'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    db = done_log.size();
    rst = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("midrst_req_addr", {32'd0, req_addr}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    tick(2);
    rst = 1'b1;
    m_err = 1'b0;
    tick(3);
    chk("midrst_no_done", 64'(done_log.size() - db), 64'd0);
    load(0, 1'b1, WRITE_ADDR0, 64'd5, 1'b0);
    load(1, 1'b0, DONE_ALL, 64'd0, 1'b0);
    plan(0, 1, 1'b0, 64'h77);
    run(2, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      int k;
      cnt = $urandom_range(1, N);
      k = 0;
      for (int i = 0; i < cnt; i++) begin
        bit w;
        w = 1'($urandom_range(0, 1));
        load(i, w, $urandom, {$urandom, $urandom}, 1'b0);
        if (!w) begin
          if ($urandom_range(0, 9) == 0) plan(k, 0, 1'b1, 64'd0);
          else if ($urandom_range(0, 7) == 0) plan(k, TMO - 1, 1'b0, {$urandom, $urandom});
          else plan(k, $urandom_range(0, 6), 1'b0, {$urandom, $urandom});
          k++;
        end
      end
      run(cnt, 1'($urandom_range(0, 1)));
    end

`ifdef SOFTREG_CMD_SEQ_POLL_EN
    // Poll read answered 0, 0, then 5: three requests, one result.
    begin
      int rb2, sb2, db2;
      load(0, 1'b0, DONE_ALL, 64'd0, 1'b1);
      plan(0, 1, 1'b0, 64'd0);
      plan(1, 1, 1'b0, 64'd0);
      plan(2, 2, 1'b0, 64'd5);
      rb2 = req_log.size(); sb2 = res_log.size(); db2 = done_log.size();
      cmd_count = 4'd1; start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int n = 0; n < 200 && done_log.size() == db2; n++) tick(1);
      tick(2);
      chk("poll_req_count", 64'(req_log.size() - rb2), 64'd3);
      chk("poll_res_count", 64'(res_log.size() - sb2), 64'd1);
      if (res_log.size() > sb2) chk("poll_res_data", res_log[sb2].d, 64'd5);
      chk("poll_err", {63'd0, timeout_err}, 64'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/softreg_cmd_seq.md
Name: softreg_cmd_seq

Overview:
- Parametrised host-side SoftReg command sequencer; successor to the fixed per-cycle SoftReg stimulus used in the top-level bench.
- Holds a loadable table of N_CMDS commands, each a write or a read. On start, issues them in order on the SoftReg request channel and waits for each read response with a timeout.
- Reports read results on a result port, with done/error status.
- Sits between bench or host logic and the PageRank SoftReg interface.

Parameters:
- N_CMDS, 8, command table depth (>=2); IDX_W = $clog2(N_CMDS).
- ADDR_W, 32, SoftReg address width.
- DATA_W, 64, SoftReg data width.
- GAP_CYC, 2, idle cycles inserted after each completed command (0 allowed).
- TIMEOUT_CYC, 1024, maximum cycles to wait for a read response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- cmd_wr_en  in  1  load one table entry.
- cmd_wr_idx  in  IDX_W  entry index.
- cmd_wr_is_write  in  1  entry kind: 1 = write, 0 = read.
- cmd_wr_addr  in  ADDR_W  entry address.
- cmd_wr_data  in  DATA_W  entry write data; ignored for reads.
- cmd_count  in  IDX_W+1  number of entries to run (1..N_CMDS).
- start  in  1  begin a run; sampled only in IDLE.
- softreg_req_valid  out  1  request strobe, exactly 1 cycle per command.
- softreg_req_isWrite  out  1  request kind.
- softreg_req_addr  out  ADDR_W  request address.
- softreg_req_data  out  DATA_W  request data.
- softreg_resp_valid  in  1  read response strobe.
- softreg_resp_data  in  DATA_W  read response data.
- res_valid  out  1  one-cycle pulse per completed read.
- res_idx  out  IDX_W  table index of the completed read.
- res_data  out  DATA_W  captured read data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; index, gap and timeout counters go to 0; table contents undefined.
- Table writes:
  - Accepted only in IDLE.
  - Ignored while busy, and ignored when cmd_wr_idx >= N_CMDS.
- FSM states and transitions:
  - IDLE: on start=1 with cmd_count in 1..N_CMDS → ISSUE, with idx=0 and timeout_err cleared. On start with cmd_count=0 or cmd_count>N_CMDS: done pulses next cycle, state stays IDLE, no request is issued.
  - ISSUE: drives req_valid=1 plus entry[idx] fields (all registered outputs) for one cycle. A write → GAP. A read → WAIT, with the timeout counter cleared.
  - WAIT: resp_valid in the first WAIT cycle or later → capture data; res_valid=1 with res_idx=idx on the next cycle; → GAP. If TIMEOUT_CYC cycles elapse with no response: timeout_err=1, → DONE (run aborted).
  - GAP: counts GAP_CYC cycles (0 means skip this state). Then, if idx == cmd_count-1 → DONE; else idx++ and → ISSUE.
  - DONE: done=1 for one cycle → IDLE.
- resp_valid outside WAIT is ignored and is not buffered.
- A response arriving in the same cycle as the timeout expiry is accepted; no error is raised.
- start while busy is ignored.
- Reset asserted mid-run aborts immediately; no done pulse is produced.
- Write-only run latency: (1 + GAP_CYC) per command, plus 1 cycle for DONE.

Optional Feature:
- Macro SOFTREG_CMD_SEQ_POLL_EN.
- When defined, each table entry gains a poll bit, loaded via an added port cmd_wr_poll (in, 1). For a read entry with poll=1, a response of 0 does not complete the command: the FSM waits GAP_CYC cycles, then reissues the same read. This repeats until a nonzero response arrives, or until TIMEOUT_CYC total cycles have elapsed since the first issue, which raises timeout_err.
- res_valid fires only for the final nonzero response. Intended use is polling DONE_ALL.
- When not defined, the port and the poll storage are absent and every read completes on its first response.

Decomposition:
- Shared package softreg_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP, DONE);
  - the softreg_cmd_t struct {is_write, poll, addr, data};
  - the SoftReg address constants WRITE_ADDR0 and DONE_ALL, migrated from the constants header.
- One sub-module, softreg_cmd_table: a synchronous-write, asynchronous-read register array of softreg_cmd_t.

Test Plan:
- Load 2 entries (write 0x10←256, read DONE_ALL); bench responds 3 cycles after the read; start with cmd_count=2 → one write request, one read request, res_valid with idx=1 and the response data, then done; timeout_err=0.
- Four writes, GAP_CYC=2 → req_valid pulses exactly 3 cycles apart; done arrives 13 cycles after start.
- Read with no response, TIMEOUT_CYC=16 → timeout_err=1 after 16 cycles, then done; a subsequent start clears timeout_err.
- start with cmd_count=0, and a separate start with cmd_count=9 → done next cycle, no req_valid. A start during a running run is ignored, with no extra requests.
- Reset pulled low mid-WAIT → all outputs 0 immediately; after release, a fresh start runs the table normally.
- POLL_EN: poll read answered with 0, 0, then 5 → 3 requests issued; a single res_valid with data 5.
